// File: rtl/adder_prefix_seq_pkg.sv
// Shared width default, stage-count derivation and FSM encodings for the
// iterative Kogge-Stone prefix adder.
`ifndef LEN_DATA
`define LEN_DATA 32
`endif

package adder_prefix_seq_pkg;

    localparam int LEN_DATA_DEF = `LEN_DATA;

    function automatic int clog2(input int n);
        int r;
        r = 0;
        for (int i = 0; i < 31; i++) begin
            if ((1 << i) < n) begin
                r = i + 1;
            end
        end
        return r;
    endfunction

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_PREFIX = 2'd1,
        ST_DONE   = 2'd2
    } state_t;

endpackage

// File: rtl/adder_prefix_seq_span.sv
// One generic Kogge-Stone prefix row: span 2^k selected at run time.
// Purely combinational; bits below the span pass straight through.
module gp_cell (
    input  logic i_gl,
    input  logic i_pl,
    input  logic i_gr,
    input  logic i_pr,
    output logic o_g,
    output logic o_p
);
    assign o_g = i_gl | (i_pl & i_gr);
    assign o_p = i_pl & i_pr;
endmodule

module adder_prefix_span
    import adder_prefix_seq_pkg::*;
#(
    parameter int LEN_DATA = LEN_DATA_DEF,
    parameter int KW       = 3
) (
    input  logic [LEN_DATA-1:0] i_g,
    input  logic [LEN_DATA-1:0] i_p,
    input  logic [KW-1:0]       i_k,
    output logic [LEN_DATA-1:0] o_g,
    output logic [LEN_DATA-1:0] o_p
);
    logic [31:0]         w_span;
    logic [LEN_DATA-1:0] w_g_sh;
    logic [LEN_DATA-1:0] w_p_sh;
    logic [LEN_DATA-1:0] w_low;
    logic [LEN_DATA-1:0] w_g_cell;
    logic [LEN_DATA-1:0] w_p_cell;

    // Shifting left by the span lines bit i up with its right operand i-2^k.
    always_comb begin
        w_span = 32'd1 << i_k;
        w_g_sh = i_g << w_span;
        w_p_sh = i_p << w_span;
        w_low  = (LEN_DATA'(1) << w_span) - LEN_DATA'(1);
    end

    for (genvar i = 0; i < LEN_DATA; i++) begin : g_cell
        gp_cell u_cell (
            .i_gl (i_g[i]),
            .i_pl (i_p[i]),
            .i_gr (w_g_sh[i]),
            .i_pr (w_p_sh[i]),
            .o_g  (w_g_cell[i]),
            .o_p  (w_p_cell[i])
        );
    end

    assign o_g = (w_low & i_g) | (~w_low & w_g_cell);
    assign o_p = (w_low & i_p) | (~w_low & w_p_cell);

endmodule

// File: rtl/adder_prefix_seq.sv
// Multi-cycle Kogge-Stone add/sub: one prefix row reused for STAGES cycles.
// Result valid STAGES cycles after accept; held stable until out_ready.
module adder_prefix_seq
    import adder_prefix_seq_pkg::*;
#(
    parameter int LEN_DATA = LEN_DATA_DEF
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                in_valid,
    output logic                in_ready,
    input  logic [LEN_DATA-1:0] a,
    input  logic [LEN_DATA-1:0] b,
    input  logic                cin,
    input  logic                sub,
    output logic                out_valid,
    input  logic                out_ready,
    output logic [LEN_DATA-1:0] sum,
    output logic                cout,
    output logic                overflow
);
    localparam int STAGES = clog2(LEN_DATA);
    localparam int KW     = clog2(STAGES + 1);

    state_t              r_state;
    logic [KW-1:0]       r_k;
    logic [LEN_DATA-1:0] r_g;
    logic [LEN_DATA-1:0] r_p;
    logic [LEN_DATA-1:0] r_h;
    logic                r_c0;

    logic [LEN_DATA-1:0] w_bb;
    logic                w_c0;
    logic [LEN_DATA-1:0] w_h;
    logic [LEN_DATA-1:0] w_g_init;
    logic [LEN_DATA-1:0] w_g_nxt;
    logic [LEN_DATA-1:0] w_p_nxt;
    logic [LEN_DATA-1:0] w_c;

    // Carry-in is folded into G[0] so the prefix tree needs no extra column.
    always_comb begin
        w_bb        = sub ? ~b : b;
        w_c0        = sub | cin;
        w_h         = a ^ w_bb;
        w_g_init    = a & w_bb;
        w_g_init[0] = (a[0] & w_bb[0]) | (w_h[0] & w_c0);
    end

    adder_prefix_span #(
        .LEN_DATA (LEN_DATA),
        .KW       (KW)
    ) u_span (
        .i_g (r_g),
        .i_p (r_p),
        .i_k (r_k),
        .o_g (w_g_nxt),
        .o_p (w_p_nxt)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= ST_IDLE;
            r_k     <= '0;
            r_g     <= '0;
            r_p     <= '0;
            r_h     <= '0;
            r_c0    <= 1'b0;
        end else begin
            case (r_state)
                ST_IDLE: begin
                    if (in_valid) begin
                        r_g     <= w_g_init;
                        r_p     <= w_h;
                        r_h     <= w_h;
                        r_c0    <= w_c0;
                        r_k     <= '0;
                        r_state <= ST_PREFIX;
                    end
                end
                ST_PREFIX: begin
                    r_g <= w_g_nxt;
                    r_p <= w_p_nxt;
                    r_k <= r_k + KW'(1);
                    if (r_k == KW'(STAGES - 1)) begin
                        r_state <= ST_DONE;
                    end
                end
                ST_DONE: begin
                    if (out_ready) begin
                        r_state <= ST_IDLE;
                    end
                end
                default: begin
                    r_state <= ST_IDLE;
                    r_k     <= '0;
                end
            endcase
        end
    end

    assign w_c       = {r_g[LEN_DATA-2:0], r_c0};
    assign sum       = r_h ^ w_c;
    assign cout      = r_g[LEN_DATA-1];
    assign overflow  = w_c[LEN_DATA-1] ^ r_g[LEN_DATA-1];
    assign in_ready  = (r_state == ST_IDLE) && !rst;
    assign out_valid = (r_state == ST_DONE);

endmodule

// File: tb/tb_adder_prefix_seq.sv
// Randomised and directed bench for adder_prefix_seq against an arithmetic model.
module tb_adder_prefix_seq;
    localparam int W = 32;

    logic         clk = 1'b0;
    logic         rst;
    logic         in_valid;
    logic         in_ready;
    logic [W-1:0] a;
    logic [W-1:0] b;
    logic         cin;
    logic         sub;
    logic         out_valid;
    logic         out_ready;
    logic [W-1:0] sum;
    logic         cout;
    logic         overflow;

    int n_cmp = 0;
    int n_bad = 0;

    adder_prefix_seq #(.LEN_DATA(W)) dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .a         (a),
        .b         (b),
        .cin       (cin),
        .sub       (sub),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .sum       (sum),
        .cout      (cout),
        .overflow  (overflow)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_cmp++;
        if (obs !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    // Returns {overflow, cout, sum} from plain integer arithmetic.
    function automatic logic [W+1:0] model(input logic [W-1:0] x, input logic [W-1:0] y,
                                           input logic ci, input logic s);
        logic [W-1:0] yy;
        logic [W:0]   t;
        logic         ov;
        yy = s ? ~y : y;
        t  = {1'b0, x} + {1'b0, yy} + (W+1)'(s | ci);
        ov = (x[W-1] == yy[W-1]) && (t[W-1] != x[W-1]);
        return {ov, t};
    endfunction

    task automatic do_op(input string tag, input logic [W-1:0] x, input logic [W-1:0] y,
                         input logic ci, input logic s, input logic [W+1:0] exp, input int hold);
        int lat;
        @(negedge clk);
        a = x; b = y; cin = ci; sub = s; in_valid = 1'b1; out_ready = 1'b0;
        chk({tag, "/in_ready"}, in_ready, 1);
        @(negedge clk);
        in_valid = 1'b0;
        lat = 0;
        while (!out_valid && lat < 20) begin
            @(negedge clk);
            lat++;
        end
        chk({tag, "/latency"}, lat, 5);
        chk({tag, "/result"}, {overflow, cout, sum}, exp);
        chk({tag, "/busy"}, in_ready, 0);
        for (int h = 0; h < hold; h++) begin
            in_valid = 1'b1; a = $urandom; b = $urandom; cin = ~ci; sub = ~s;
            @(negedge clk);
            chk({tag, "/hold"}, {out_valid, in_ready, overflow, cout, sum}, {2'b10, exp});
        end
        in_valid = 1'b0; out_ready = 1'b1;
        @(negedge clk);
        out_ready = 1'b0;
        chk({tag, "/release"}, {in_ready, out_valid}, 2'b10);
    endtask

    logic [W-1:0] qa[$];
    logic [W-1:0] qb[$];
    logic         qc[$];
    logic         qs[$];
    logic [W+1:0] qexp[$];
    int           acc_cyc[$];

    initial begin
        logic [W-1:0] ra, rb;
        logic         rc, rs;
        int           idx, got, cyc, stale;

        rst = 1'b1; in_valid = 1'b0; out_ready = 1'b0;
        a = '0; b = '0; cin = 1'b0; sub = 1'b0;
        #12;
        chk("reset/outs", {in_ready, out_valid, overflow, cout, sum}, '0);
        @(negedge clk);
        rst = 1'b0;

        do_op("add_wrap", 32'hFFFF_FFFF, 32'h0000_0001, 1'b0, 1'b0, {1'b0, 1'b1, 32'h0000_0000}, 0);
        do_op("add_ovf",  32'h7FFF_FFFF, 32'h0000_0001, 1'b0, 1'b0, {1'b1, 1'b0, 32'h8000_0000}, 0);
        do_op("sub_brw",  32'h0000_0005, 32'h0000_0007, 1'b0, 1'b1, {1'b0, 1'b0, 32'hFFFF_FFFE}, 0);
        do_op("bp_cin",   32'h1234_5678, 32'h0FED_CBA8, 1'b1, 1'b0, {1'b0, 1'b0, 32'h2222_2221}, 3);

        for (int i = 0; i < 25; i++) begin
            ra = $urandom; rb = $urandom; rc = 1'($urandom); rs = 1'($urandom);
            if (i % 5 == 0) rb = ra;
            do_op("rand", ra, rb, rc, rs, model(ra, rb, rc, rs), int'($urandom_range(0, 2)));
        end

        // Reset two PREFIX edges into an operation.
        @(negedge clk);
        a = 32'hDEAD_BEEF; b = 32'h1357_9BDF; cin = 1'b1; sub = 1'b0; in_valid = 1'b1;
        @(negedge clk);
        in_valid = 1'b0;
        @(negedge clk);
        @(negedge clk);
        rst = 1'b1;
        #1;
        chk("rst_mid/outs", {in_ready, out_valid, sum}, '0);
        @(negedge clk);
        rst = 1'b0;
        #1;
        chk("rst_mid/in_ready", in_ready, 1);
        stale = 0;
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            if (out_valid) stale++;
        end
        chk("rst_mid/no_stale", stale, 0);

        // Back-to-back with continuous valid/ready.
        qa.push_back(32'h0000_0001); qb.push_back(32'h0000_0001); qc.push_back(1'b0); qs.push_back(1'b0);
        qa.push_back(32'h8000_0000); qb.push_back(32'h8000_0000); qc.push_back(1'b0); qs.push_back(1'b0);
        qexp.push_back({1'b0, 1'b0, 32'h0000_0002});
        qexp.push_back({1'b1, 1'b1, 32'h0000_0000});
        for (int i = 0; i < 6; i++) begin
            ra = $urandom; rb = $urandom; rc = 1'($urandom); rs = 1'($urandom);
            qa.push_back(ra); qb.push_back(rb); qc.push_back(rc); qs.push_back(rs);
            qexp.push_back(model(ra, rb, rc, rs));
        end
        idx = 0; got = 0; cyc = 0;
        out_ready = 1'b1;
        while (got < qa.size() && cyc < 400) begin
            @(negedge clk);
            cyc++;
            if (out_valid) begin
                chk("b2b/result", {overflow, cout, sum}, qexp[got]);
                got++;
            end
            if (in_ready) begin
                if (idx < qa.size()) begin
                    a = qa[idx]; b = qb[idx]; cin = qc[idx]; sub = qs[idx];
                    in_valid = 1'b1;
                    acc_cyc.push_back(cyc);
                    idx++;
                end else begin
                    in_valid = 1'b0;
                end
            end
        end
        in_valid = 1'b0;
        chk("b2b/count", got, qa.size());
        for (int i = 1; i < acc_cyc.size(); i++) begin
            chk("b2b/spacing", acc_cyc[i] - acc_cyc[i-1], 7);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not complete, got timeout expected finish");
        $fatal(1);
    end

endmodule

// File: doc/adder_prefix_seq.md
Name: adder_prefix_seq

Overview:
Multi-cycle sequencer for the Kogge-Stone parallel-prefix add datapath, for area-constrained configurations.
- Instantiates one generic span-d prefix stage (a row of gp_cell) and iterates it over clog2(LEN_DATA) cycles, instead of building log2 unrolled stages.
- Sits between the execute-stage issue logic and writeback.
- Uses a valid/ready handshake on both sides; performs add, add-with-carry and subtract.

Parameters:
- LEN_DATA, default `LEN_DATA (32): operand width; must be a power of two, >= 2.
- STAGES, default clog2(LEN_DATA) (5): number of prefix iterations; derived, not overridden.

Ports:
- clk  input  1  clock; all state updates on the rising edge.
- rst  input  1  asynchronous, active-high reset.
- in_valid  input  1  operand request valid.
- in_ready  output  1  sequencer can accept an operand request.
- a  input  LEN_DATA  operand A.
- b  input  LEN_DATA  operand B.
- cin  input  1  carry-in; ignored when sub=1.
- sub  input  1  1 selects A - B.
- out_valid  output  1  result valid.
- out_ready  input  1  consumer accepts the result.
- sum  output  LEN_DATA  result.
- cout  output  1  carry out of the MSB; for subtract, 0 means a borrow occurred.
- overflow  output  1  signed overflow.

Behaviour:
- States are IDLE, PREFIX and DONE; a 2-bit state register plus a clog2(STAGES+1)-bit stage counter k.
- Reset (asynchronous, active-high) forces:
  - state=IDLE, k=0;
  - registers G, P, H and c0 all cleared to 0;
  - hence out_valid=0, sum=0, cout=0, overflow=0;
  - in_ready=0 while rst=1.
- Reset asserted in any state aborts the operation; no result from an aborted operation ever appears after reset releases.
- in_ready=1 only in IDLE with rst=0. out_valid=1 only in DONE.
- IDLE: on in_valid && in_ready, capture on the edge and go to PREFIX with k=0:
  - bb = sub ? ~b : b;
  - c0 = sub | cin;
  - H = a ^ bb;
  - G[i] = a[i] & bb[i] for i>0;
  - G[0] = (a[0] & bb[0]) | (H[0] & c0);
  - P = H.
- PREFIX: each edge applies span d = 2^k.
  - For i >= d: G[i] <= G[i] | (P[i] & G[i-d]); P[i] <= P[i] & P[i-d].
  - For i < d: G[i] and P[i] are unchanged.
  - k increments by 1.
  - On the edge applying k=STAGES-1, go to DONE.
- Latency: out_valid rises exactly STAGES cycles after the accept edge (5 cycles for a 32-bit width).
- DONE:
  - Outputs are combinational from the registers:
    - carry c[0]=c0, c[i]=G[i-1];
    - sum = H ^ c;
    - cout = G[LEN_DATA-1];
    - overflow = c[LEN_DATA-1] ^ cout.
  - sum, cout and overflow stay stable while out_valid=1 && out_ready=0.
  - On out_ready=1 go to IDLE. There is no same-cycle re-accept, so the throughput limit is 1 operation per STAGES+2 cycles.
- in_valid is ignored outside IDLE. Input values are sampled only at the accept edge; changes to a, b, cin or sub during PREFIX or DONE have no effect.
- Illegal state encoding: recover to IDLE on the next edge.

Decomposition:
- Shared define/package holds:
  - `LEN_DATA;
  - the STAGES derivation (clog2 function);
  - the state encodings ST_IDLE=2'd0, ST_PREFIX=2'd1, ST_DONE=2'd2.
- One sub-module, adder_prefix_span:
  - combinational;
  - inputs are G, P and a span select k;
  - instantiates one gp_cell per bit, with the right operand muxed to index i-2^k;
  - for i < 2^k it passes bits through unchanged.
- The sequencer owns all registers and the FSM.

Test Plan:
1. a=0xFFFFFFFF, b=0x00000001, cin=0, sub=0 -> sum=0x00000000, cout=1, overflow=0; out_valid rises exactly 5 cycles after the accept edge.
2. a=0x7FFFFFFF, b=0x00000001, cin=0, sub=0 -> sum=0x80000000, cout=0, overflow=1.
3. a=0x00000005, b=0x00000007, sub=1, cin=0 -> sum=0xFFFFFFFE, cout=0 (borrow), overflow=0.
4. Back-pressure: first operation a=0x12345678, b=0x0FEDCBA8, cin=1 completes with sum=0x22222221, cout=0, and out_ready is held 0 for 3 cycles:
   - sum and out_valid stay stable, in_ready=0;
   - a concurrent in_valid with different operands is not captured;
   - after out_ready=1, in_ready returns to 1 the next cycle.
5. Reset mid-operation: assert rst for 1 cycle, 2 cycles into PREFIX -> out_valid=0, sum=0 immediately; after release in_ready=1, and no stale out_valid appears within 10 cycles.
6. Back-to-back operations at in_valid=1 continuously with out_ready=1:
   - (0x00000001 + 0x00000001) -> sum 0x00000002;
   - then (0x80000000 + 0x80000000) -> sum 0x00000000, cout=1, overflow=1;
   - successive accepts are spaced exactly STAGES+2=7 cycles apart.
